// File: rtl/hd_lzc_seq.sv
// Sequenced leading-zero counter: scans a word MSB-first one CHUNK-bit slice per
// cycle, stops at the first non-zero slice, returns count and all-zero flag.
module hd_lzc_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    out_count_o,
  output logic             out_zero_o
);

  localparam int unsigned NS = WIDTH / CHUNK;
  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;

  logic [CHUNK-1:0] top_slice;
  logic [CW-1:0]    top_lzc;

  // Leading zeros inside one non-zero slice (0..CHUNK-1).
  function automatic logic [CW-1:0] slice_lzc(input logic [CHUNK-1:0] s);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
      if (!hit) begin
        if (s[i]) hit = 1'b1;
        else      n   = n + CW'(1);
      end
    end
    return n;
  endfunction

  assign top_slice = sr_q[WIDTH-1 -: CHUNK];
  assign top_lzc   = slice_lzc(top_slice);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sr_d    = in_data_i;
          idx_d   = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (top_slice != '0) begin
          out_count_d = acc_q + top_lzc;
          out_zero_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == IW'(NS - 1)) begin
          out_count_d = CW'(WIDTH);
          out_zero_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d = acc_q + CW'(CHUNK);
          sr_d  = sr_q << CHUNK;
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign out_count_o = out_count_q;
  assign out_zero_o  = out_zero_q;

endmodule
